// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the MIPS EX stage.
//
// The block holds only shift registers, muxes and an iteration counter. Every
// add, subtract and negate is done by an external shared 32-bit adder.
// add_a/add_b/add_op are driven combinationally from state and registers.
// add_sum/add_carry are consumed in the same cycle and registered at the edge.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any operation, no done
//   start      request, sampled only while idle
//   op         00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   rs_val     multiplicand / dividend
//   rt_val     multiplier / divisor
//   busy       high while an operation is in progress
//   done       one-cycle pulse; hi/lo/div_zero are valid from this cycle on
//   hi, lo     product[63:32]/[31:0], or remainder/quotient
//   div_zero   divide with a zero divisor (hi = rs_val, lo = all ones)
//   add_a, add_b, add_op   operands and op (0 add, 1 subtract) for the adder
//   add_sum, add_carry     adder result; carry on add, borrow on subtract
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_op,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_carry
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_NEG_A  = 3'd1,
      S_NEG_B  = 3'd2,
      S_ITER   = 3'd3,
      S_FIX_LO = 3'd4,
      S_FIX_HI = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;          // op[1]: signed, op[0]: divide
   logic [31:0] a_q, a_d;            // multiplicand / dividend magnitude
   logic [31:0] b_q, b_d;            // multiplier / divisor magnitude
   logic [31:0] h_q, h_d;            // product high / partial remainder
   logic [31:0] l_q, l_d;            // product low / quotient
   logic [4:0]  cnt_q, cnt_d;
   logic        sign_a_q, sign_a_d;
   logic        sign_b_q, sign_b_d;
   logic        dz_q, dz_d;          // divide-by-zero seen for this operation
   logic        lo_zero_q, lo_zero_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        div_zero_q, div_zero_d;
   logic [31:0] b_new_s;
   logic        neg_s;

   assign busy     = busy_q;
   assign done     = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = div_zero_q;

   // Next-state, datapath and adder-port decode.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      h_d        = h_q;
      l_d        = l_q;
      cnt_d      = cnt_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      dz_d       = dz_q;
      lo_zero_d  = lo_zero_q;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
      add_a      = 32'd0;
      add_b      = 32'd0;
      add_op     = 1'b0;
      b_new_s    = b_q;
      neg_s      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d       = op;
               a_d        = rs_val;
               b_d        = rt_val;
               // h/l preloaded with the divide-by-zero result; ITER entry
               // overwrites them for every other path.
               h_d        = rs_val;
               l_d        = 32'hFFFF_FFFF;
               cnt_d      = 5'd0;
               sign_a_d   = op[1] & rs_val[31];
               sign_b_d   = op[1] & rt_val[31];
               dz_d       = 1'b0;
               lo_zero_d  = 1'b0;
               div_zero_d = 1'b0;
               if (op[1]) begin
                  state_d = S_NEG_A;
               end else if (op[0] && (rt_val == 32'd0)) begin
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  h_d     = 32'd0;
                  l_d     = op[0] ? rs_val : rt_val;
                  state_d = S_ITER;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_NEG_A: begin
            add_a  = 32'd0;
            add_b  = a_q;
            add_op = 1'b1;
            if (a_q[31]) begin
               a_d = add_sum;
            end else begin
               a_d = a_q;
            end
            state_d = S_NEG_B;
         end

         S_NEG_B: begin
            add_a  = 32'd0;
            add_b  = b_q;
            add_op = 1'b1;
            if (b_q[31]) begin
               b_new_s = add_sum;
            end else begin
               b_new_s = b_q;
            end
            b_d = b_new_s;
            // Negation preserves zero, so the raw divisor decides.
            if (op_q[0] && (b_q == 32'd0)) begin
               dz_d    = 1'b1;
               state_d = S_DONE;
            end else begin
               h_d     = 32'd0;
               l_d     = op_q[0] ? a_q : b_new_s;
               cnt_d   = 5'd0;
               state_d = S_ITER;
            end
         end

         S_ITER: begin
            if (!op_q[0]) begin
               // Shift-add: add multiplicand when the multiplier LSB is set,
               // then shift {carry, sum, L} right by one.
               add_a  = h_q;
               add_b  = l_q[0] ? a_q : 32'd0;
               add_op = 1'b0;
               h_d    = {add_carry, add_sum[31:1]};
               l_d    = {add_sum[0], l_q[31:1]};
            end else begin
               // Restoring divide: R' = {R,Q} << 1 (33 bits); subtract when
               // R' >= divisor, i.e. R'[32] set or no borrow.
               add_a  = {h_q[30:0], l_q[31]};
               add_b  = b_q;
               add_op = 1'b1;
               if (h_q[31] || !add_carry) begin
                  h_d = add_sum;
                  l_d = {l_q[30:0], 1'b1};
               end else begin
                  h_d = {h_q[30:0], l_q[31]};
                  l_d = {l_q[30:0], 1'b0};
               end
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = op_q[1] ? S_FIX_LO : S_DONE;
            end else begin
               state_d = S_ITER;
            end
         end

         S_FIX_LO: begin
            // Low word / quotient negates when operand signs differ.
            add_a     = 32'd0;
            add_b     = l_q;
            add_op    = 1'b1;
            lo_zero_d = (l_q == 32'd0);
            if (sign_a_q ^ sign_b_q) begin
               l_d = add_sum;
            end else begin
               l_d = l_q;
            end
            state_d = S_FIX_HI;
         end

         S_FIX_HI: begin
            if (!op_q[0]) begin
               // High word of a 64-bit negate: ~H plus the carry out of -L,
               // which is 1 only when L was zero.
               add_a  = ~h_q;
               add_b  = {31'd0, lo_zero_q};
               add_op = 1'b0;
               neg_s  = sign_a_q ^ sign_b_q;
            end else begin
               // Remainder follows the dividend's sign.
               add_a  = 32'd0;
               add_b  = h_q;
               add_op = 1'b1;
               neg_s  = sign_a_q;
            end
            if (neg_s) begin
               h_d = add_sum;
            end else begin
               h_d = h_q;
            end
            state_d = S_DONE;
         end

         S_DONE: begin
            hi_d       = h_q;
            lo_d       = l_q;
            div_zero_d = dz_q;
            done_d     = 1'b1;
            state_d    = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= 2'd0;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         h_q        <= 32'd0;
         l_q        <= 32'd0;
         cnt_q      <= 5'd0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         dz_q       <= 1'b0;
         lo_zero_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         h_q        <= h_d;
         l_q        <= l_d;
         cnt_q      <= cnt_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         dz_q       <= dz_d;
         lo_zero_q  <= lo_zero_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
      end
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the MIPS core.
- Drives one external shared 32-bit adder/subtractor and produces the HI/LO results.
- Sits beside the ALU in EX. The pipeline stalls on busy and captures hi/lo on done.
- Holds no arithmetic of its own beyond shifts, muxes and a counter; every add, subtract and negate goes through the adder ports.

Parameters:
WIDTH, 32, operand width; only 32 is supported (fixed by the adder).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
op  input  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV
rs_val  input  32  multiplicand / dividend
rt_val  input  32  multiplier / divisor
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when results are valid
hi  output  32  MULT: product[63:32]; DIV: remainder
lo  output  32  MULT: product[31:0]; DIV: quotient
div_zero  output  1  set with done when a DIV/DIVU divisor was 0
add_a  output  32  adder num1
add_b  output  32  adder num2
add_op  output  1  adder op: 0 add, 1 subtract
add_sum  input  32  adder sum (combinational response)
add_carry  input  1  add: carry out; subtract: borrow (1 when add_a < add_b unsigned)

Behaviour:
- Reset: state IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0, all internal regs 0. Reset mid-operation aborts with no done pulse.
- Adder ports are driven combinationally from state and registers. add_sum/add_carry are used in the same cycle and registered at the edge.
- States: IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE.
- IDLE:
  - On start, latch op, rs_val, rt_val, and sign flags (signed ops only).
  - Go to NEG_A if op[1]=1, else ITER.
  - start while busy is ignored; no queuing.
- NEG_A: add_a=0, add_b=A, add_op=1. Latch A:=add_sum if A[31] is set, else keep A. Go to NEG_B.
- NEG_B: same operation on B. Go to ITER.
- Divide by zero: detected on entry to ITER (B==0).
  - Skip ITER, FIX_LO and FIX_HI; go to DONE.
  - Results: hi = original rs_val, lo = 32'hFFFF_FFFF, div_zero=1.
- ITER: exactly 32 cycles; counter 0..31, leave after count 31.
- Multiply (P = {H,L}, H=0, L=multiplier):
  - add_a=H, add_b = L[0] ? mcand : 0, add_op=0.
  - {H,L} := {add_carry, add_sum, L} >> 1.
- Divide (R=0, Q=dividend):
  - Shift {R,Q} left 1 giving 33-bit R'.
  - add_a=R'[31:0], add_b=divisor, add_op=1.
  - If R'[32] or !add_carry: R:=add_sum and Q bit0:=1. Else R:=R'[31:0] and Q bit0:=0.
- After ITER: go to FIX_LO if op[1]=1, else DONE.
- Signed fix-up, always both FIX cycles:
  - MULT: negate 64-bit product if sign(A) != sign(B).
    - FIX_LO: add_a=0, add_b=L, add_op=1; L:=add_sum. Record lo_zero = (old L==0).
    - FIX_HI: add_a=~H, add_b={31'b0, lo_zero}, add_op=0; H:=add_sum.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
    - FIX_LO negates Q when needed.
    - FIX_HI negates R (add_a=0, add_b=R, add_op=1) when needed.
  - When no negation is needed, registers hold and the adder output is ignored.
- DONE:
  - done=1 for exactly one cycle; hi/lo update in this cycle. Return to IDLE.
  - hi/lo/div_zero then hold until the next DONE.
  - div_zero clears on the next accepted start.
- Latency, with start high at edge k and done high in the cycle after edge k+N:
  - N=33 unsigned; N=37 signed.
  - N=3 signed divide-by-zero; N=1 unsigned divide-by-zero.
- busy rises the cycle after the accepting edge. A new start is accepted in the cycle after done.
- Overflow (0x80000000 / -1) follows the same algorithm: lo=0x80000000, hi=0.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> done at start+33; hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
- MULT 0xFFFFFFFD (-3) × 7 -> done at start+37; hi=0xFFFFFFFF, lo=0xFFFFFFEB; add_op=1 seen in NEG_A and FIX_LO.
- DIVU 100 / 7 -> lo=14, hi=2, div_zero=0. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 5 / 0 -> done at start+1, div_zero=1, lo=0xFFFFFFFF, hi=5. Next MULTU 2×3 -> div_zero=0, lo=6.
- Start pulses at cycles 5 and 10 of a running MULTU -> ignored; single done, result unchanged. Back-to-back start in the cycle after done -> accepted.
- rst asserted at ITER count 12 -> next cycle busy=0, hi=lo=0, no done. Fresh DIVU 0x80000000 / 3 -> lo=0x2AAAAAAA, hi=2.
